// File: rtl/cp0_except_ctrl_if.sv
// Pipeline <-> CP0 exception controller bundle: MEM-stage exception inputs,
// MTC0/MFC0 access, hardware interrupts and the flush/redirect results.
interface cp0_except_if;
  logic        MEM_Valid;
  logic [8:0]  MEM_ExceptType;
  logic [31:0] MEM_PC;
  logic        MEM_IsDelaySlot;
  logic [31:0] MEM_BadVAddr;
  logic [5:0]  ext_int;
  logic        cp0_we;
  logic [4:0]  cp0_waddr;
  logic [31:0] cp0_wdata;
  logic [4:0]  cp0_raddr;
  logic [31:0] cp0_rdata;
  logic        flush_all;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        int_pending;

  modport master (
    output MEM_Valid, MEM_ExceptType, MEM_PC, MEM_IsDelaySlot, MEM_BadVAddr,
    output ext_int, cp0_we, cp0_waddr, cp0_wdata, cp0_raddr,
    input  cp0_rdata, flush_all, redirect_valid, redirect_pc, int_pending
  );

  modport slave (
    input  MEM_Valid, MEM_ExceptType, MEM_PC, MEM_IsDelaySlot, MEM_BadVAddr,
    input  ext_int, cp0_we, cp0_waddr, cp0_wdata, cp0_raddr,
    output cp0_rdata, flush_all, redirect_valid, redirect_pc, int_pending
  );
endinterface

// File: rtl/cp0_except_ctrl.sv
// CP0 exception controller: resolves exceptions/ERET for the MEM instruction,
// owns BadVAddr/Count/Compare/Status/Cause/EPC and drives flush + PC redirect.
module cp0_except_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
  parameter logic [31:0] RESET_STATUS = 32'h0040_0000
) (
  input logic         clk,
  input logic         rst,
  cp0_except_if.slave bus
);

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  logic [7:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic        r_ti;
  logic [1:0]  r_ip_sw;
  logic [5:0]  r_ext_int;
  logic [4:0]  r_exccode;
  logic [31:0] r_epc;
  logic [31:0] r_badvaddr;
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_tick;

  logic        w_exc;
  logic        w_eret;
  logic        w_wr;
  logic [4:0]  w_code;
  logic        w_bad_pc;
  logic        w_bad_data;
  logic [7:0]  w_ip;
  logic [31:0] w_count_inc;
  logic [31:0] w_status;
  logic [31:0] w_cause;
  logic [31:0] w_epc_next;
  logic [31:0] w_redirect_pc;
  logic [31:0] w_rdata;

  // Eret (bit 2) is not an exception source; any other set bit outranks it.
  assign w_exc  = bus.MEM_Valid & (|{bus.MEM_ExceptType[8:3], bus.MEM_ExceptType[1:0]});
  assign w_eret = bus.MEM_Valid & bus.MEM_ExceptType[2] & ~w_exc;
  assign w_wr   = bus.cp0_we & ~w_exc & ~w_eret;

  assign w_count_inc = r_count + 32'd1;
  assign w_ip        = {r_ext_int[5] | r_ti, r_ext_int[4:0], r_ip_sw};
  assign w_status    = {9'd0, 1'b1, 6'd0, r_im, 6'd0, r_exl, r_ie};
  assign w_cause     = {r_bd, r_ti, 14'd0, w_ip, 1'b0, r_exccode, 2'd0};
  assign w_epc_next  = bus.MEM_IsDelaySlot ? (bus.MEM_PC - 32'd4) : bus.MEM_PC;

  // Priority encoder: ExcCode and which BadVAddr source the winner uses
  always_comb begin
    w_code     = 5'd0;
    w_bad_pc   = 1'b0;
    w_bad_data = 1'b0;
    if (bus.MEM_ExceptType[8]) begin
      w_code = 5'd0;
    end else if (bus.MEM_ExceptType[7]) begin
      w_code   = 5'd4;
      w_bad_pc = 1'b1;
    end else if (bus.MEM_ExceptType[6]) begin
      w_code = 5'd10;
    end else if (bus.MEM_ExceptType[5]) begin
      w_code = 5'd12;
    end else if (bus.MEM_ExceptType[4]) begin
      w_code = 5'd8;
    end else if (bus.MEM_ExceptType[3]) begin
      w_code = 5'd9;
    end else if (bus.MEM_ExceptType[1]) begin
      w_code     = 5'd5;
      w_bad_data = 1'b1;
    end else if (bus.MEM_ExceptType[0]) begin
      w_code     = 5'd4;
      w_bad_data = 1'b1;
    end else begin
      w_code = 5'd0;
    end
  end

  // Redirect target selection, forced to 0 while reset is held
  always_comb begin
    w_redirect_pc = 32'd0;
    if (rst) begin
      w_redirect_pc = 32'd0;
    end else if (w_exc) begin
      w_redirect_pc = EXC_VECTOR;
    end else if (w_eret) begin
      w_redirect_pc = r_epc;
    end else begin
      w_redirect_pc = 32'd0;
    end
  end

  assign bus.redirect_pc    = w_redirect_pc;
  assign bus.flush_all      = ~rst & (w_exc | w_eret);
  assign bus.redirect_valid = ~rst & (w_exc | w_eret);
  assign bus.int_pending    = ~rst & r_ie & ~r_exl & (|(w_ip & r_im));

  // MFC0 read mux; shows pre-edge state only
  always_comb begin
    w_rdata = 32'd0;
    case (bus.cp0_raddr)
      REG_BADVADDR: w_rdata = r_badvaddr;
      REG_COUNT:    w_rdata = r_count;
      REG_COMPARE:  w_rdata = r_compare;
      REG_STATUS:   w_rdata = w_status;
      REG_CAUSE:    w_rdata = w_cause;
      REG_EPC:      w_rdata = r_epc;
      default:      w_rdata = 32'd0;
    endcase
  end

  assign bus.cp0_rdata = w_rdata;

  // Status/Cause/EPC/BadVAddr: exception > ERET > MTC0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_im       <= RESET_STATUS[15:8];
      r_exl      <= RESET_STATUS[1];
      r_ie       <= RESET_STATUS[0];
      r_bd       <= 1'b0;
      r_exccode  <= 5'd0;
      r_ip_sw    <= 2'd0;
      r_epc      <= 32'd0;
      r_badvaddr <= 32'd0;
    end else if (w_exc) begin
      r_exccode <= w_code;
      r_exl     <= 1'b1;
      if (!r_exl) begin
        r_epc <= w_epc_next;
        r_bd  <= bus.MEM_IsDelaySlot;
      end
      if (w_bad_pc) begin
        r_badvaddr <= bus.MEM_PC;
      end else if (w_bad_data) begin
        r_badvaddr <= bus.MEM_BadVAddr;
      end
    end else if (w_eret) begin
      r_exl <= 1'b0;
    end else if (w_wr) begin
      case (bus.cp0_waddr)
        REG_STATUS: begin
          r_im  <= bus.cp0_wdata[15:8];
          r_exl <= bus.cp0_wdata[1];
          r_ie  <= bus.cp0_wdata[0];
        end
        REG_CAUSE: r_ip_sw <= bus.cp0_wdata[9:8];
        REG_EPC:   r_epc   <= bus.cp0_wdata;
        default:   r_ip_sw <= r_ip_sw;
      endcase
    end
  end

  // Half-rate Count, Compare match into TI, and interrupt line sampling
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick    <= 1'b0;
      r_count   <= 32'd0;
      r_compare <= 32'd0;
      r_ti      <= 1'b0;
      r_ext_int <= 6'd0;
    end else begin
      r_tick    <= ~r_tick;
      r_ext_int <= bus.ext_int;
      if (w_wr && (bus.cp0_waddr == REG_COUNT)) begin
        r_count <= bus.cp0_wdata;
      end else if (r_tick) begin
        r_count <= w_count_inc;
      end
      if (w_wr && (bus.cp0_waddr == REG_COMPARE)) begin
        r_compare <= bus.cp0_wdata;
        r_ti      <= 1'b0;
      end else if (r_tick && !(w_wr && (bus.cp0_waddr == REG_COUNT))
                   && (w_count_inc == r_compare)) begin
        r_ti <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cp0_except_ctrl.sv
// Scoreboard bench for cp0_except_ctrl: each scenario queues its expectations
// while driving stimulus, then pops them against what the DUT produced.
`timescale 1ns/1ps
module tb_cp0_except_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;

  cp0_except_if bus ();

  cp0_except_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #10 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] val;
  } sb_t;

  sb_t         exp_q[$];
  logic [31:0] obs_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic idle();
    bus.MEM_Valid       = 1'b0;
    bus.MEM_ExceptType  = 9'd0;
    bus.MEM_PC          = 32'd0;
    bus.MEM_IsDelaySlot = 1'b0;
    bus.MEM_BadVAddr    = 32'd0;
    bus.cp0_we          = 1'b0;
    bus.cp0_waddr       = 5'd0;
    bus.cp0_wdata       = 32'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string n, input logic [31:0] v);
    exp_q.push_back('{name: n, val: v});
  endtask

  task automatic observe(input logic [31:0] v);
    obs_q.push_back(v);
  endtask

  task automatic observe_reg(input logic [4:0] a);
    bus.cp0_raddr = a;
    #1;
    obs_q.push_back(bus.cp0_rdata);
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    bus.cp0_we    = 1'b1;
    bus.cp0_waddr = a;
    bus.cp0_wdata = d;
  endtask

  task automatic raise(input logic [8:0] t, input logic [31:0] pc, input logic ds);
    bus.MEM_Valid       = 1'b1;
    bus.MEM_ExceptType  = t;
    bus.MEM_PC          = pc;
    bus.MEM_IsDelaySlot = ds;
  endtask

  task automatic test_reset();
    sb_t e;
    logic [31:0] o;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    expect_val("count_after_20", 32'd10);         observe_reg(5'd9);
    #7;
    rst = 1'b1;
    raise(9'h020, 32'h8000_1004, 1'b1);
    mtc0(5'd9, 32'h0000_0055);
    #1;
    expect_val("rst_flush", 32'd0);               observe({31'd0, bus.flush_all});
    expect_val("rst_redirect_valid", 32'd0);      observe({31'd0, bus.redirect_valid});
    expect_val("rst_redirect_pc", 32'd0);         observe(bus.redirect_pc);
    expect_val("rst_int_pending", 32'd0);         observe({31'd0, bus.int_pending});
    expect_val("rst_count_async", 32'd0);         observe_reg(5'd9);
    expect_val("rst_status", 32'h0040_0000);      observe_reg(5'd12);
    step();
    idle();
    #4 rst = 1'b0;
    expect_val("post_rst_cause", 32'd0);          observe_reg(5'd13);
    expect_val("post_rst_epc", 32'd0);            observe_reg(5'd14);
    expect_val("post_rst_count", 32'd0);          observe_reg(5'd9);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hxxxx_xxxx;
      n_checks++;
      if (o !== e.val) begin
        n_errors++;
        $display("FAIL %s got %h expected %h", e.name, o, e.val);
      end
    end
  endtask

  task automatic test_ov_delay_slot();
    sb_t e;
    logic [31:0] o;
    step();
    raise(9'h020, 32'h8000_1004, 1'b1);
    bus.MEM_BadVAddr = 32'hAAAA_0000;
    #1;
    expect_val("ov_redirect_pc", 32'hBFC0_0380);  observe(bus.redirect_pc);
    expect_val("ov_flush", 32'd1);                observe({31'd0, bus.flush_all});
    expect_val("ov_redirect_valid", 32'd1);       observe({31'd0, bus.redirect_valid});
    step();
    idle();
    expect_val("ov_epc", 32'h8000_1000);          observe_reg(5'd14);
    expect_val("ov_cause", 32'h8000_0030);        observe_reg(5'd13);
    expect_val("ov_status", 32'h0040_0002);       observe_reg(5'd12);
    expect_val("ov_badvaddr", 32'd0);             observe_reg(5'd8);
    expect_val("ov_flush_idle", 32'd0);           observe({31'd0, bus.flush_all});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hxxxx_xxxx;
      n_checks++;
      if (o !== e.val) begin
        n_errors++;
        $display("FAIL %s got %h expected %h", e.name, o, e.val);
      end
    end
  endtask

  task automatic test_eret();
    sb_t e;
    logic [31:0] o;
    step();
    raise(9'h004, 32'h8000_0100, 1'b0);
    #1;
    expect_val("eret_redirect_pc", 32'h8000_1000); observe(bus.redirect_pc);
    expect_val("eret_flush", 32'd1);               observe({31'd0, bus.flush_all});
    step();
    idle();
    expect_val("eret_status", 32'h0040_0000);      observe_reg(5'd12);
    expect_val("eret_cause", 32'h8000_0030);       observe_reg(5'd13);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hxxxx_xxxx;
      n_checks++;
      if (o !== e.val) begin
        n_errors++;
        $display("FAIL %s got %h expected %h", e.name, o, e.val);
      end
    end
  endtask

  task automatic test_timer();
    sb_t e;
    logic [31:0] o;
    logic found;
    step(); mtc0(5'd9, 32'd0);
    step(); mtc0(5'd11, 32'd5);
    step(); mtc0(5'd12, 32'h0040_8001);
    step(); idle();
    expect_val("tmr_status", 32'h0040_8001);      observe_reg(5'd12);
    expect_val("tmr_no_int_yet", 32'd0);          observe({31'd0, bus.int_pending});
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!found) begin
        step();
        if (bus.int_pending === 1'b1) found = 1'b1;
      end
    end
    expect_val("tmr_int_within_bound", 32'd1);    observe({31'd0, found});
    expect_val("tmr_count_at_ti", 32'd5);         observe_reg(5'd9);
    expect_val("tmr_cause_ti", 32'hC000_8030);    observe_reg(5'd13);
    step(); mtc0(5'd11, 32'd100);
    expect_val("tmr_compare_pre_edge", 32'd5);    observe_reg(5'd11);
    expect_val("tmr_int_pre_edge", 32'd1);        observe({31'd0, bus.int_pending});
    step(); idle();
    expect_val("tmr_int_cleared", 32'd0);         observe({31'd0, bus.int_pending});
    expect_val("tmr_cause_cleared", 32'h8000_0030); observe_reg(5'd13);
    expect_val("tmr_compare_new", 32'd100);       observe_reg(5'd11);
    step(); bus.ext_int = 6'b100000;
    #1;
    expect_val("ext_int_not_yet", 32'd0);         observe({31'd0, bus.int_pending});
    step();
    expect_val("ext_int_pending", 32'd1);         observe({31'd0, bus.int_pending});
    expect_val("ext_int_cause", 32'h8000_8030);   observe_reg(5'd13);
    bus.ext_int = 6'd0;
    step();
    expect_val("ext_int_dropped", 32'd0);         observe({31'd0, bus.int_pending});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hxxxx_xxxx;
      n_checks++;
      if (o !== e.val) begin
        n_errors++;
        $display("FAIL %s got %h expected %h", e.name, o, e.val);
      end
    end
  endtask

  task automatic test_adel_if();
    sb_t e;
    logic [31:0] o;
    step();
    raise(9'h0C0, 32'h8000_0002, 1'b0);
    mtc0(5'd14, 32'h0000_1234);
    #1;
    expect_val("adel_redirect_pc", 32'hBFC0_0380); observe(bus.redirect_pc);
    expect_val("adel_flush", 32'd1);               observe({31'd0, bus.flush_all});
    step(); idle();
    expect_val("adel_cause", 32'h0000_0010);       observe_reg(5'd13);
    expect_val("adel_epc", 32'h8000_0002);         observe_reg(5'd14);
    expect_val("adel_badvaddr", 32'h8000_0002);    observe_reg(5'd8);
    expect_val("adel_status", 32'h0040_8003);      observe_reg(5'd12);
    expect_val("adel_int_masked", 32'd0);          observe({31'd0, bus.int_pending});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hxxxx_xxxx;
      n_checks++;
      if (o !== e.val) begin
        n_errors++;
        $display("FAIL %s got %h expected %h", e.name, o, e.val);
      end
    end
  endtask

  task automatic test_nested();
    sb_t e;
    logic [31:0] o;
    step(); mtc0(5'd14, 32'h8000_1000);
    step(); idle();
    step();
    raise(9'h010, 32'h8000_2000, 1'b1);
    #1;
    expect_val("nest_redirect_pc", 32'hBFC0_0380); observe(bus.redirect_pc);
    expect_val("nest_flush", 32'd1);               observe({31'd0, bus.flush_all});
    step(); idle();
    expect_val("nest_epc", 32'h8000_1000);         observe_reg(5'd14);
    expect_val("nest_cause", 32'h0000_0020);       observe_reg(5'd13);
    step();
    raise(9'h00C, 32'h8000_2004, 1'b0);
    #1;
    expect_val("eret_bp_redirect", 32'hBFC0_0380); observe(bus.redirect_pc);
    step(); idle();
    expect_val("eret_bp_cause", 32'h0000_0024);    observe_reg(5'd13);
    expect_val("eret_bp_status", 32'h0040_8003);   observe_reg(5'd12);
    step();
    raise(9'h004, 32'h8000_2008, 1'b0);
    #1;
    expect_val("nest_eret_pc", 32'h8000_1000);     observe(bus.redirect_pc);
    step(); idle();
    expect_val("nest_eret_status", 32'h0040_8001); observe_reg(5'd12);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hxxxx_xxxx;
      n_checks++;
      if (o !== e.val) begin
        n_errors++;
        $display("FAIL %s got %h expected %h", e.name, o, e.val);
      end
    end
  endtask

  task automatic test_back_to_back();
    sb_t e;
    logic [31:0] o;
    logic [31:0] d;
    step();
    raise(9'h1FF, 32'h8000_3000, 1'b0);
    bus.MEM_Valid = 1'b0;
    mtc0(5'd14, 32'h0BAD_0000);
    #1;
    expect_val("bubble_flush", 32'd0);             observe({31'd0, bus.flush_all});
    expect_val("bubble_redirect", 32'd0);          observe({31'd0, bus.redirect_valid});
    step();
    idle();
    raise(9'h1FF, 32'h8000_3000, 1'b0);
    #1;
    expect_val("bubble_epc_written", 32'h0BAD_0000); observe_reg(5'd14);
    step();
    raise(9'h002, 32'h8000_3004, 1'b0);
    bus.MEM_BadVAddr = 32'hDEAD_BEEC;
    #1;
    expect_val("int_prio_cause", 32'h0000_0000);   observe_reg(5'd13);
    expect_val("int_prio_epc", 32'h8000_3000);     observe_reg(5'd14);
    expect_val("int_prio_badvaddr", 32'h8000_0002); observe_reg(5'd8);
    step(); idle();
    expect_val("ades_badvaddr", 32'hDEAD_BEEC);    observe_reg(5'd8);
    expect_val("ades_cause", 32'h0000_0014);       observe_reg(5'd13);
    expect_val("ades_epc_kept", 32'h8000_3000);    observe_reg(5'd14);
    step(); mtc0(5'd13, 32'hFFFF_FFFF);
    step(); mtc0(5'd8, 32'h0000_0001);
    expect_val("cause_ip_sw", 32'h0000_0314);      observe_reg(5'd13);
    step(); mtc0(5'd12, 32'h0000_FF01);
    step(); idle();
    expect_val("badvaddr_ro", 32'hDEAD_BEEC);      observe_reg(5'd8);
    expect_val("status_fields", 32'h0040_FF01);    observe_reg(5'd12);
    expect_val("sw_int_pending", 32'd1);           observe({31'd0, bus.int_pending});
    expect_val("unimpl_reg0", 32'd0);              observe_reg(5'd0);
    expect_val("unimpl_reg15", 32'd0);             observe_reg(5'd15);
    step(); mtc0(5'd9, 32'hFFFF_FFFF);
    step(); idle();
    d = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      if (d === 32'hFFFF_FFFF) begin
        bus.cp0_raddr = 5'd9;
        #1;
        d = bus.cp0_rdata;
        if (d === 32'hFFFF_FFFF) step();
      end
    end
    expect_val("count_wrap", 32'd0);               observe(d);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hxxxx_xxxx;
      n_checks++;
      if (o !== e.val) begin
        n_errors++;
        $display("FAIL %s got %h expected %h", e.name, o, e.val);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    bus.ext_int   = 6'd0;
    bus.cp0_raddr = 5'd0;
    test_reset();
    test_ov_delay_slot();
    test_eret();
    test_timer();
    test_adel_if();
    test_nested();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
